// File: rtl/color_decoder_pkg.sv
// rtl/color_decoder_pkg.sv - palette colours, digit codes and FSM state encoding for the colour decoder
package color_decoder_pkg;

    localparam logic [11:0] C_BLACK   = 12'h000;
    localparam logic [11:0] C_RED     = 12'hF00;
    localparam logic [11:0] C_ORANGE  = 12'hF80;
    localparam logic [11:0] C_YELLOW  = 12'hFF0;
    localparam logic [11:0] C_GREEN   = 12'h0F0;
    localparam logic [11:0] C_CYAN    = 12'h0FF;
    localparam logic [11:0] C_AZURE   = 12'h08F;
    localparam logic [11:0] C_BLUE    = 12'h00F;
    localparam logic [11:0] C_MAGENTA = 12'hF0F;
    localparam logic [11:0] C_WHITE   = 12'hFFF;

    localparam logic [3:0] D0 = 4'd0;
    localparam logic [3:0] D1 = 4'd1;
    localparam logic [3:0] D2 = 4'd2;
    localparam logic [3:0] D3 = 4'd3;
    localparam logic [3:0] D4 = 4'd4;
    localparam logic [3:0] D5 = 4'd5;
    localparam logic [3:0] D6 = 4'd6;
    localparam logic [3:0] D7 = 4'd7;
    localparam logic [3:0] D8 = 4'd8;
    localparam logic [3:0] D9 = 4'd9;

    localparam logic [1:0] S_TENS = 2'd0;
    localparam logic [1:0] S_ONES = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

endpackage

// File: rtl/color_classify.sv
// rtl/color_classify.sv - exact-match RGB444 palette lookup to a decimal digit
module color_classify
    import color_decoder_pkg::*;
(
    input  logic [11:0] color,
    output logic [3:0]  digit,
    output logic        hit
);

    always_comb begin
        digit = D0;
        hit   = 1'b1;
        case (color)
            C_BLACK:   digit = D0;
            C_RED:     digit = D1;
            C_ORANGE:  digit = D2;
            C_YELLOW:  digit = D3;
            C_GREEN:   digit = D4;
            C_CYAN:    digit = D5;
            C_AZURE:   digit = D6;
            C_BLUE:    digit = D7;
            C_MAGENTA: digit = D8;
            C_WHITE:   digit = D9;
            default:   hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/color_decoder.sv
// rtl/color_decoder.sv - decodes two debounced colour digits into a 6-bit number with error flag
module color_decoder
    import color_decoder_pkg::*;
#(
    parameter int STABLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] color,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  num,
    output logic        err
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [3:0] last;
    logic       last_vld;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       abort;

    logic [3:0] digit;
    logic       hit;
    logic [3:0] cnt_nxt;
    logic       latch;
    logic [6:0] value;

    color_classify u_classify (
        .color (color),
        .digit (digit),
        .hit   (hit)
    );

    assign in_ready  = (state == S_TENS) || (state == S_ONES);
    assign out_valid = (state == S_OUT);

    always_comb begin
        cnt_nxt = (last_vld && (last == digit)) ? cnt + 4'd1 : 4'd1;
        latch   = (cnt_nxt == STABLE_C);
    end

    // Result derives from registers that only change outside S_OUT, so it holds under backpressure.
    assign value = {3'b000, tens} * 7'd10 + {3'b000, ones};
    assign err   = abort || (value > 7'd63);
    assign num   = err ? 6'd0 : value[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_TENS;
            cnt      <= 4'd0;
            last     <= D0;
            last_vld <= 1'b0;
            tens     <= D0;
            ones     <= D0;
            abort    <= 1'b0;
        end else begin
            case (state)
                S_TENS, S_ONES: begin
                    if (in_valid) begin
                        if (!hit) begin
                            abort <= 1'b1;
                            state <= S_OUT;
                        end else if (latch) begin
                            cnt      <= 4'd0;
                            last_vld <= 1'b0;
                            if (state == S_TENS) begin
                                tens  <= digit;
                                state <= S_ONES;
                            end else begin
                                ones  <= digit;
                                state <= S_OUT;
                            end
                        end else begin
                            cnt      <= cnt_nxt;
                            last     <= digit;
                            last_vld <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state    <= S_TENS;
                        cnt      <= 4'd0;
                        last_vld <= 1'b0;
                        abort    <= 1'b0;
                    end
                end
                default: state <= S_TENS;
            endcase
        end
    end

endmodule

// File: tb/tb_color_decoder.sv
// tb/tb_color_decoder.sv - randomized and directed self-checking bench for color_decoder
module tb_color_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [2];
    logic [11:0] col  [2];
    logic        ordy [2];
    logic        irdy [2];
    logic        ovld [2];
    logic [5:0]  num  [2];
    logic        err  [2];

    always #5 clk = ~clk;

    color_decoder #(.STABLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .color(col[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .num(num[0]), .err(err[0])
    );

    color_decoder #(.STABLE(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .color(col[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .num(num[1]), .err(err[1])
    );

    localparam logic [11:0] PAL [10] = '{12'h000, 12'hF00, 12'hF80, 12'hFF0, 12'h0F0,
                                         12'h0FF, 12'h08F, 12'h00F, 12'hF0F, 12'hFFF};
    int stab [2] = '{1, 3};

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: phase 0=tens, 1=ones, 2=result; a digit is accepted once the
    // most recent STABLE samples since the last latch are all that digit.
    int m_phase [2];
    int m_tens  [2];
    int m_num   [2];
    int m_err   [2];
    int win     [2][16];
    int wlen    [2];

    function automatic int lookup(logic [11:0] c);
        for (int i = 0; i < 10; i++)
            if (PAL[i] == c) return i;
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_tens[k] = 0; m_num[k] = 0; m_err[k] = 0; wlen[k] = 0;
        end
    endtask

    task automatic model_step(int k);
        int  d;
        int  v;
        bit  st;
        if (m_phase[k] == 2) begin
            if (ordy[k]) begin
                m_phase[k] = 0;
                wlen[k]    = 0;
            end
        end else if (iv[k]) begin
            d = lookup(col[k]);
            if (d < 0) begin
                m_phase[k] = 2; m_num[k] = 0; m_err[k] = 1;
            end else begin
                for (int i = 15; i > 0; i--) win[k][i] = win[k][i-1];
                win[k][0] = d;
                if (wlen[k] < 16) wlen[k]++;
                st = (wlen[k] >= stab[k]);
                for (int i = 0; i < stab[k]; i++)
                    if (win[k][i] != d) st = 0;
                if (st) begin
                    wlen[k] = 0;
                    if (m_phase[k] == 0) begin
                        m_tens[k]  = d;
                        m_phase[k] = 1;
                    end else begin
                        v          = m_tens[k] * 10 + d;
                        m_num[k]   = (v > 63) ? 0 : v;
                        m_err[k]   = (v > 63) ? 1 : 0;
                        m_phase[k] = 2;
                    end
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("in_ready[%0d]", k), int'(irdy[k]), (m_phase[k] != 2) ? 1 : 0);
                chk($sformatf("out_valid[%0d]", k), int'(ovld[k]), (m_phase[k] == 2) ? 1 : 0);
                if (m_phase[k] == 2) begin
                    chk($sformatf("num[%0d]", k), int'(num[k]), m_num[k]);
                    chk($sformatf("err[%0d]", k), int'(err[k]), m_err[k]);
                end
            end
        end
    end

    task automatic send(int k, logic [11:0] c);
        bit rd;
        bit ok;
        ok = 0;
        iv[k]  = 1'b1;
        col[k] = c;
        for (int n = 0; n < 20 && !ok; n++) begin
            rd = irdy[k];
            @(posedge clk); #1;
            if (rd) ok = 1;
        end
        iv[k] = 1'b0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout[%0d]: sample %h not accepted", k, c);
        end
    endtask

    task automatic expect_out(int k, int en, int ee, string name);
        for (int n = 0; n < 20 && !ovld[k]; n++) begin
            @(posedge clk); #1;
        end
        chk({name, "_valid"}, int'(ovld[k]), 1);
        chk({name, "_num"}, int'(num[k]), en);
        chk({name, "_err"}, int'(err[k]), ee);
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        chk({name, "_consumed"}, int'(ovld[k]), 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; col[k] = 12'h000; ordy[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid[%0d]", k), int'(ovld[k]), 0);
            chk($sformatf("rst_num[%0d]", k), int'(num[k]), 0);
            chk($sformatf("rst_err[%0d]", k), int'(err[k]), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", int'(irdy[0]), 1);

        send(0, 12'hF00);
        send(0, 12'h0F0);
        chk("latency", int'(ovld[0]), 1);
        expect_out(0, 14, 0, "f14");

        send(0, 12'h08F);
        send(0, 12'hFF0);
        expect_out(0, 63, 0, "f63");
        send(0, 12'h08F);
        send(0, 12'h0F0);
        expect_out(0, 0, 1, "f64");

        send(0, 12'h123);
        chk("abort_valid", int'(ovld[0]), 1);
        iv[0]  = 1'b1;
        col[0] = 12'hF00;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", int'(irdy[0]), 0);
            chk("bp_num", int'(num[0]), 0);
            chk("bp_err", int'(err[0]), 1);
            @(posedge clk); #1;
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp_release_valid", int'(ovld[0]), 0);
        chk("bp_release_ready", int'(irdy[0]), 1);

        send(1, 12'hFF0); send(1, 12'hFF0); send(1, 12'hF00);
        send(1, 12'hFF0); send(1, 12'hFF0);
        chk("s3_no_early", int'(ovld[1]), 0);
        send(1, 12'hFF0);
        send(1, 12'h000); send(1, 12'h000); send(1, 12'h000);
        expect_out(1, 30, 0, "s3_f30");

        send(0, 12'hF80);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", int'(ovld[0]), 0);
        chk("arst_ready", int'(irdy[0]), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        send(0, 12'hF80);
        send(0, 12'h00F);
        expect_out(0, 27, 0, "f27");

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k] = ($urandom % 4) != 0;
                if (($urandom % 3) == 0)
                    col[k] = (($urandom % 8) == 0) ? 12'($urandom) : PAL[$urandom % 10];
                ordy[k] = ($urandom % 3) == 0;
            end
            if (cyc == 1500) begin
                #3 rst = 1'b1;
                #3 rst = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
